// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the counter mode control slice
package counter_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    localparam int COUNT_W_DEF = 4;

    function automatic int count_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus debounce FSM for a raw push-button
module btn_debounce
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LAST = DEBOUNCE_CYCLES - 2;

    logic sync_a;
    logic sync_b;
    deb_state_t state_q;
    deb_state_t state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic done;

    // bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
        end
    end

    // debounce state and stable-sample counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // the sample that leaves a settled state counts as the first stable one
    assign done = int'(cnt_q) >= LAST;

    // next state; press_pulse flags the edge on which a press is accepted
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync_b) begin
                    cnt_d = '0;
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_d     = PRESSED;
                        press_pulse = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!sync_b) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync_b) begin
                    cnt_d   = '0;
                    state_d = (DEBOUNCE_CYCLES <= 1) ? RELEASED : RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (sync_b) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (done) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/counter_mode_ctrl.sv
// counter_mode_ctrl: direction control for the up/down counter (button toggle
// plus ping-pong lookahead); MODE_CTRL_STATUS_EN adds the rev_cnt status port
module counter_mode_ctrl
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    input  logic               auto_en,
    input  logic [COUNT_W-1:0] count,
    output logic               mode,
    output logic               mode_chg,
`ifdef MODE_CTRL_STATUS_EN
    output logic               btn_press,
    output logic [7:0]         rev_cnt
`else
    output logic               btn_press
`endif
);

    localparam logic [COUNT_W-1:0] PRE_MAX = COUNT_W'(count_max(COUNT_W) - 1);
    localparam logic [COUNT_W-1:0] PRE_MIN = COUNT_W'(1);

    logic press_pulse;
    logic level;
    logic btn_evt;
    logic flip_up;
    logic flip_dn;
    logic toggle;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .press_pulse(press_pulse),
        .level      (level)
    );

    // a press is only ever accepted from the released level
    assign btn_evt = press_pulse & ~level;
    // reverse one step early so the counter turns at the end of range
    assign flip_up = auto_en & ~mode & (count == PRE_MAX);
    assign flip_dn = auto_en & mode & (count == PRE_MIN);
    assign toggle  = btn_evt | flip_up | flip_dn;

    // direction register with registered change and press pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode      <= 1'b0;
            mode_chg  <= 1'b0;
            btn_press <= 1'b0;
        end else begin
            mode      <= mode ^ toggle;
            mode_chg  <= toggle;
            btn_press <= btn_evt;
        end
    end

`ifdef MODE_CTRL_STATUS_EN
    // saturating count of direction changes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rev_cnt <= 8'd0;
        end else if (mode_chg && rev_cnt != 8'hFF) begin
            rev_cnt <= rev_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_counter_mode_ctrl.sv
// tb_counter_mode_ctrl: directed bench for counter_mode_ctrl driving a live 4-bit counter
module tb_counter_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       auto_en = 1'b0;
    logic       live = 1'b0;
    logic [3:0] cnt_live;
    logic [3:0] cnt_force = 4'd0;
    logic [3:0] count;
    logic       mode;
    logic       mode_chg;
    logic       btn_press;
`ifdef MODE_CTRL_STATUS_EN
    logic [7:0] rev_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic       auto_en;
        logic [3:0] cnt;
        logic       exp_chg;
        logic       exp_mode;
    } vec_t;

    vec_t tbl[14];

    assign count = live ? cnt_live : cnt_force;

    counter_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .COUNT_W(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .auto_en  (auto_en),
        .count    (count),
        .mode     (mode),
        .mode_chg (mode_chg),
`ifdef MODE_CTRL_STATUS_EN
        .btn_press(btn_press),
        .rev_cnt  (rev_cnt)
`else
        .btn_press(btn_press)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt_live <= 4'd0;
        else if (live) cnt_live <= mode ? cnt_live - 4'd1 : cnt_live + 4'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 4'd14, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'd13, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'd15, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'd1,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'd14, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 4'd14, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 4'd0,  1'b0, 1'b1};
        tbl[7]  = '{1'b0, 4'd1,  1'b0, 1'b1};
        tbl[8]  = '{1'b1, 4'd2,  1'b0, 1'b1};
        tbl[9]  = '{1'b1, 4'd1,  1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'd1,  1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'd14, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 4'd1,  1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'd14, 1'b0, 1'b0};

        #3;
        chk("reset mode", int'(mode), 0);
        chk("reset mode_chg", int'(mode_chg), 0);
        chk("reset btn_press", int'(btn_press), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            auto_en = tbl[i].auto_en;
            cnt_force = tbl[i].cnt;
            tick();
            chk($sformatf("vec%0d mode_chg", i), int'(mode_chg), int'(tbl[i].exp_chg));
            chk($sformatf("vec%0d mode", i), int'(mode), int'(tbl[i].exp_mode));
            chk($sformatf("vec%0d btn_press", i), int'(btn_press), 0);
        end
        auto_en = 1'b0;
        cnt_force = 4'd5;

        btn_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("press e%0d btn_press", k), int'(btn_press), int'(k == 6));
            chk($sformatf("press e%0d mode_chg", k), int'(mode_chg), int'(k == 6));
            chk($sformatf("press e%0d mode", k), int'(mode), int'(k >= 6));
        end
        btn_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("release e%0d btn_press", k), int'(btn_press), 0);
            chk($sformatf("release e%0d mode_chg", k), int'(mode_chg), 0);
        end
        chk("release mode", int'(mode), 1);

        btn_in = 1'b1;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("midrst mode", int'(mode), 0);
        chk("midrst mode_chg", int'(mode_chg), 0);
        chk("midrst btn_press", int'(btn_press), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("repress e%0d btn_press", k), int'(btn_press), int'(k == 6));
            chk($sformatf("repress e%0d mode", k), int'(mode), int'(k >= 6));
        end
        btn_in = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        do_reset();
        for (int k = 1; k <= 16; k++) begin
            btn_in = (k <= 3) || (k >= 5 && k <= 7);
            tick();
            chk($sformatf("bounce e%0d btn_press", k), int'(btn_press), 0);
            chk($sformatf("bounce e%0d mode", k), int'(mode), 0);
        end
        btn_in = 1'b0;

        do_reset();
        live = 1'b1;
        auto_en = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("pingpong e%0d count", k), int'(count),
                (k <= 15) ? k : (k <= 30) ? 30 - k : k - 30);
            chk($sformatf("pingpong e%0d mode_chg", k), int'(mode_chg),
                int'(k == 15 || k == 30));
        end

        do_reset();
        for (int k = 1; k <= 20; k++) begin
            if (k == 10) btn_in = 1'b1;
            tick();
            chk($sformatf("collide e%0d mode_chg", k), int'(mode_chg), int'(k == 15));
            chk($sformatf("collide e%0d btn_press", k), int'(btn_press), int'(k == 15));
            chk($sformatf("collide e%0d mode", k), int'(mode), int'(k >= 15));
            chk($sformatf("collide e%0d count", k), int'(count), (k <= 15) ? k : 30 - k);
        end
        btn_in = 1'b0;
        live = 1'b0;
        auto_en = 1'b0;
        for (int k = 0; k < 8; k++) tick();

`ifdef MODE_CTRL_STATUS_EN
        do_reset();
        chk("status reset rev_cnt", int'(rev_cnt), 0);
        auto_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cnt_force = (i % 2 == 0) ? 4'd14 : 4'd1;
            tick();
            chk($sformatf("status r%0d mode", i), int'(mode), int'(i % 2 == 0));
            if (i == 9) chk("status mid rev_cnt", int'(rev_cnt), 9);
        end
        auto_en = 1'b0;
        cnt_force = 4'd5;
        tick();
        tick();
        chk("status sat rev_cnt", int'(rev_cnt), 255);
        do_reset();
        #1;
        chk("status post-reset rev_cnt", int'(rev_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_mode_ctrl.md
# counter_mode_ctrl

Upstream control stage for the 4-bit up/down counter: drives its `mode` input. Converts a raw, bouncy push-button into a debounced single press event that toggles count direction. Optionally runs the counter in ping-pong fashion by watching the counter's `count` feedback and reversing direction one step before each end of range, so the counter never wraps.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change (≥1).
- `COUNT_W`, default 4: width of the counter feedback.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `btn_in`  in  1: raw asynchronous push-button, 1 = pressed.
- `auto_en`  in  1: synchronous; 1 = ping-pong auto-reverse enabled.
- `count`  in  COUNT_W: current counter value (feedback).
- `mode`  out  1: direction to counter; 0 = up, 1 = down.
- `mode_chg`  out  1: one-cycle pulse on the cycle `mode` takes a new value.
- `btn_press`  out  1: one-cycle pulse per accepted press.

## Operation
- `btn_in` passes through a 2-flop synchronizer, then a debounce FSM:
  - RELEASED: sync=1 → PRESS_WAIT, clear counter.
  - PRESS_WAIT: sync=1 counts; reaching DEBOUNCE_CYCLES → PRESSED, pulse `btn_press`. sync=0 → RELEASED.
  - PRESSED: sync=0 → RELEASE_WAIT.
  - RELEASE_WAIT: sync=0 counts; reaching DEBOUNCE_CYCLES → RELEASED, no pulse. sync=1 → PRESSED.
- Any mismatching sample restarts the count. A held button yields exactly one press.
- Auto-reverse lookahead applies only when `auto_en`=1:
  - flip_up: `mode`=0 and `count`==MAX-1.
  - flip_dn: `mode`=1 and `count`==1.
  - MAX = 2^COUNT_W−1.
- Toggle when `btn_press` event OR flip_up OR flip_dn. `mode` <= ~`mode`, and `mode_chg` is pulsed on the same edge.
- Simultaneous events cause a single toggle and a single `mode_chg` pulse.
- If `auto_en` rises while `count`==MAX in up mode, or `count`==0 in down mode, the counter wraps once. Ping-pong resumes at the next lookahead. Not an error.

## Timing
- Reset, asynchronous and immediate:
  - `mode`=0, `mode_chg`=0, `btn_press`=0.
  - Synchronizer flops 0, FSM in RELEASED, debounce counter 0.
- Reset mid-debounce aborts the press; no pulse is emitted.
- Press latency: with edge 1 the first edge sampling `btn_in`=1, `btn_press`, the `mode` toggle and `mode_chg` all become visible after edge 2+DEBOUNCE_CYCLES.
- Auto-reverse: `mode` flips on the same edge on which the counter moves MAX-1→MAX, or 1→0. The counter therefore uses the new direction on the next edge.
  - Resulting sequence: …MAX-1, MAX, MAX-1… and …1, 0, 1…
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `MODE_CTRL_STATUS_EN` defined:
  - Adds output `rev_cnt` [7:0], counting `mode_chg` pulses.
  - Saturates at 255.
  - Reset value 0.
- Undefined: port and logic are absent. All other behaviour is identical.

## Structure
- Shared package `counter_pkg` holds:
  - Debounce state enum typedef: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - `COUNT_W` default constant and the MAX derivation.
- One sub-module, `btn_debounce`: synchronizer plus debounce FSM, with outputs `press_pulse` and `level`.
- The top holds the direction register, lookahead compare and optional status counter.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and drives `mode` into a live 4-bit counter.
- Reset mid-operation: `mode`=1 and PRESS_WAIT, `rst` driven low between edges → `mode`, `mode_chg`, `btn_press` read 0 immediately. After release, a press needs the full 6 edges again.
- Clean press: `btn_in` held high 12 cycles → `btn_press` and `mode_chg` each pulse once after edge 6, `mode` 0→1, no further pulses. Release → no pulse.
- Bounce: `btn_in` high 3 cycles, low 1, high 3, low → no `btn_press`, `mode` stays 0.
- Ping-pong: `auto_en`=1 from count 0 → count 0…15,14…1,0,1 with no wrap. `mode_chg` on the 14→15 and 1→0 edges.
- Collision: press timed so acceptance coincides with `count`==14 in up mode → exactly one `mode_chg`, `mode` 0→1, counter 15→14.
- With `MODE_CTRL_STATUS_EN`: 300 forced reversals → `rev_cnt` reads 255. Reset → 0.
